seq_repeat_checker: RTL and testbench

- Synthesizable, cycle-accurate monitor for the consecutive-repetition property `cond[*MIN_REP]`.
- One attempt may start on every sampled cycle; attempts overlap, so several can fail on the same sample.
- Also flags runs longer than MAX_REP and keeps pass/fail statistics.
- Sits downstream of the design signals (the `r1 < r2` style comparisons) and feeds the debug/status register block.

---
 rtl/seq_repeat_checker.sv | 88 ++++++++
 tb/tb_seq_repeat_checker.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_repeat_checker.sv
// seq_repeat_checker: overlapping cond[*MIN_REP] monitor with overrun detection and pass/fail statistics
module seq_repeat_checker #(
  parameter int MIN_REP = 3,
  parameter int MAX_REP = 4,
  parameter int CNT_W = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic             cond,
  input  logic             start_en,
  input  logic             clear,
  output logic             pass_pulse,
  output logic             fail_pulse,
  output logic [4:0]       fail_count,
  output logic             overrun_pulse,
  output logic [4:0]       alive,
  output logic [CNT_W-1:0] pass_total,
  output logic [CNT_W-1:0] fail_total,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             halted
);
  localparam int PW = MIN_REP > 1 ? MIN_REP - 1 : 1;
  localparam int RW = $clog2(MAX_REP + 2);
  localparam int SW = CNT_W + 6;
  typedef enum logic {RUN, HALT} state_t;
  state_t state;
  logic [PW-1:0] pend, pend_n;
  logic [RW-1:0] run, run_n;
  logic [CNT_W-1:0] idx;
  logic seen, fire, pass_n, fail_n, ovr_n;
  logic [PW:0] v;
  logic [4:0] fc_n, alive_n;
  logic [SW-1:0] ps, fs;
  always_comb begin
    v = {pend, start_en};
    fire = sample_en && state == RUN;
    fc_n = cond ? 5'd0 : 5'($countones(v));
    fail_n = fc_n != 5'd0;
    pass_n = cond && (MIN_REP == 1 ? start_en : v[PW]);
    pend_n = (!cond || MIN_REP == 1) ? '0 : v[PW-1:0];
    ovr_n = cond && run >= RW'(MAX_REP);
    run_n = !cond ? '0 : (run > RW'(MAX_REP) ? run : run + 1'b1);
    alive_n = 5'($countones(pend_n));
    ps = SW'(pass_total) + SW'(pass_n);
    fs = SW'(fail_total) + SW'(fc_n);
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= RUN;
      pend <= '0;
      run <= '0;
      idx <= '0;
      seen <= 1'b0;
      pass_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      fail_count <= '0;
      overrun_pulse <= 1'b0;
      alive <= '0;
      pass_total <= '0;
      fail_total <= '0;
      first_fail_idx <= '0;
      halted <= 1'b0;
    end else begin
      pass_pulse <= fire && pass_n;
      fail_pulse <= fire && fail_n;
      fail_count <= fire ? fc_n : 5'd0;
      overrun_pulse <= fire && ovr_n;
      if (fire) begin
        pend <= pend_n;
        run <= run_n;
        idx <= idx + 1'b1;
        alive <= alive_n;
        pass_total <= ps > SW'({CNT_W{1'b1}}) ? '1 : ps[CNT_W-1:0];
        fail_total <= fs > SW'({CNT_W{1'b1}}) ? '1 : fs[CNT_W-1:0];
        if (fail_n && !seen) begin
          seen <= 1'b1;
          first_fail_idx <= idx;
        end
        if (fail_n && STOP_ON_FAIL) begin
          state <= HALT;
          halted <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seq_repeat_checker.sv
// tb_seq_repeat_checker: scoreboard bench comparing three checker configurations against an attempt-list model
module tb_seq_repeat_checker;
  localparam int MIN = 3;
  localparam int MAX = 4;
  typedef struct packed {
    logic pp, fp;
    logic [4:0] fc;
    logic ov;
    logic [4:0] al;
    logic [15:0] pt, ft, ffi;
    logic h;
  } out_t;
  logic clk = 0, rst_n = 0, clear = 0, sample_en = 0, cond = 0, start_en = 0;
  logic pp0, fp0, ov0, h0, pp1, fp1, ov1, h1, pp2, fp2, ov2, h2;
  logic [4:0] fc0, al0, fc1, al1, fc2, al2;
  logic [15:0] pt0, ft0, ffi0, pt1, ft1, ffi1;
  logic [3:0] pt2, ft2, ffi2;
  out_t obs, e;
  out_t q[$];
  int sel = 0, checks = 0, failures = 0;
  int att[$];
  int m_run, m_idx, m_pt, m_ft, m_ffi, m_maxc;
  bit m_seen, m_halt, m_stop;
  always #5 clk = ~clk;
  seq_repeat_checker #(.MIN_REP(MIN), .MAX_REP(MAX), .CNT_W(16), .STOP_ON_FAIL(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .cond(cond), .start_en(start_en), .clear(clear),
    .pass_pulse(pp0), .fail_pulse(fp0), .fail_count(fc0), .overrun_pulse(ov0), .alive(al0),
    .pass_total(pt0), .fail_total(ft0), .first_fail_idx(ffi0), .halted(h0));
  seq_repeat_checker #(.MIN_REP(MIN), .MAX_REP(MAX), .CNT_W(16), .STOP_ON_FAIL(1'b1)) u_stop (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .cond(cond), .start_en(start_en), .clear(clear),
    .pass_pulse(pp1), .fail_pulse(fp1), .fail_count(fc1), .overrun_pulse(ov1), .alive(al1),
    .pass_total(pt1), .fail_total(ft1), .first_fail_idx(ffi1), .halted(h1));
  seq_repeat_checker #(.MIN_REP(MIN), .MAX_REP(MAX), .CNT_W(4), .STOP_ON_FAIL(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .cond(cond), .start_en(start_en), .clear(clear),
    .pass_pulse(pp2), .fail_pulse(fp2), .fail_count(fc2), .overrun_pulse(ov2), .alive(al2),
    .pass_total(pt2), .fail_total(ft2), .first_fail_idx(ffi2), .halted(h2));
  always_comb
    obs = sel == 1 ? {pp1, fp1, fc1, ov1, al1, pt1, ft1, ffi1, h1} :
          sel == 2 ? {pp2, fp2, fc2, ov2, al2, 12'd0, pt2, 12'd0, ft2, 12'd0, ffi2, h2} :
                     {pp0, fp0, fc0, ov0, al0, pt0, ft0, ffi0, h0};
  task automatic model(input bit r, input bit cl, input bit se, input bit c, input bit st, output out_t x);
    int fc;
    bit pass, ovr;
    fc = 0;
    pass = 0;
    ovr = 0;
    if (r || cl) begin
      att.delete();
      m_run = 0; m_idx = 0; m_pt = 0; m_ft = 0; m_ffi = 0; m_seen = 0; m_halt = 0;
    end else if (se && !m_halt) begin
      if (st) att.push_back(0);
      if (!c) begin
        fc = att.size();
        att.delete();
        m_run = 0;
      end else begin
        foreach (att[i]) att[i]++;
        if (att.size() > 0 && att[0] == MIN) begin
          pass = 1;
          void'(att.pop_front());
        end
        m_run = m_run > MAX ? m_run : m_run + 1;
        ovr = m_run > MAX;
      end
      m_pt = m_pt + int'(pass) > m_maxc ? m_maxc : m_pt + int'(pass);
      m_ft = m_ft + fc > m_maxc ? m_maxc : m_ft + fc;
      if (fc > 0 && !m_seen) begin
        m_seen = 1;
        m_ffi = m_idx;
      end
      if (fc > 0 && m_stop) m_halt = 1;
      m_idx = (m_idx + 1) & m_maxc;
    end
    x = {pass, fc != 0, 5'(fc), ovr, 5'(att.size()), 16'(m_pt), 16'(m_ft), 16'(m_ffi), m_halt};
  endtask
  task automatic cyc(input bit r, input bit cl, input bit se, input bit c, input bit st);
    out_t x;
    rst_n = !r; clear = cl; sample_en = se; cond = c; start_en = st;
    model(r, cl, se, c, st, x);
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask
  task automatic select(input int s);
    sel = s;
    m_stop = s == 1;
    m_maxc = s == 2 ? 15 : 65535;
  endtask
  task automatic test_reset;
    select(0);
    cyc(1, 0, 1, 1, 1);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs !== out_t'(0)) begin failures++; $display("FAIL reset got=%h exp=%h", obs, e); end
  endtask
  task automatic test_pass_fail;
    bit c[4] = '{1, 1, 1, 0};
    select(0);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, c[i], 1);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL pass_fail s%0d got=%h exp=%h", i, obs, e); end
    end
    checks++;
    if (obs.fc !== 5'd3 || obs.ffi !== 16'd3 || obs.pt !== 16'd1 || obs.ft !== 16'd3)
      begin failures++; $display("FAIL pass_fail_totals got=%h exp fc=3 ffi=3 pt=1 ft=3", obs); end
  endtask
  task automatic test_all_fail;
    select(0);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 0, 1);
      e = q.pop_front();
      checks++;
      if (obs !== e || obs.fc !== 5'd1) begin failures++; $display("FAIL all_fail s%0d got=%h exp=%h", i, obs, e); end
    end
    checks++;
    if (obs.ft !== 16'd5 || obs.ffi !== 16'd0) begin failures++; $display("FAIL all_fail_totals got=%h exp ft=5 ffi=0", obs); end
  endtask
  task automatic test_overrun;
    select(0);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    for (int i = 0; i < 6; i++) begin
      cyc(0, 0, 1, 1, 1);
      e = q.pop_front();
      checks++;
      if (obs !== e || obs.ov !== (i >= 4) || obs.pp !== (i >= 2))
        begin failures++; $display("FAIL overrun s%0d got=%h exp=%h", i, obs, e); end
    end
    checks++;
    if (obs.al !== 5'd2) begin failures++; $display("FAIL overrun_alive got=%0d exp=2", obs.al); end
  endtask
  task automatic test_gaps;
    bit c[4] = '{1, 1, 1, 0};
    select(0);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, c[i], 1);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL gaps s%0d got=%h exp=%h", i, obs, e); end
      for (int g = 0; g < 3; g++) begin
        cyc(0, 0, 0, !c[i], 1);
        e = q.pop_front();
        checks++;
        if (obs !== e || obs.pp || obs.fp || obs.ov) begin failures++; $display("FAIL gaps_idle s%0d g%0d got=%h exp=%h", i, g, obs, e); end
      end
    end
    checks++;
    if (obs.ffi !== 16'd3 || obs.pt !== 16'd1 || obs.ft !== 16'd3) begin failures++; $display("FAIL gaps_totals got=%h exp ffi=3 pt=1 ft=3", obs); end
  endtask
  task automatic test_halt;
    bit c[5] = '{1, 0, 1, 1, 1};
    select(1);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, c[i], 1);
      e = q.pop_front();
      checks++;
      if (obs !== e || obs.h !== (i >= 1)) begin failures++; $display("FAIL halt s%0d got=%h exp=%h", i, obs, e); end
    end
    checks++;
    if (obs.ft !== 16'd2 || obs.pp || obs.fp) begin failures++; $display("FAIL halt_frozen got=%h exp ft=2 no pulses", obs); end
    cyc(0, 1, 1, 0, 1);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs !== out_t'(0)) begin failures++; $display("FAIL halt_clear got=%h exp=%h", obs, e); end
  endtask
  task automatic test_reset_mid;
    select(0);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    cyc(0, 0, 1, 1, 1); void'(q.pop_front());
    cyc(0, 0, 1, 1, 1);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs.al !== 5'd2) begin failures++; $display("FAIL reset_mid_alive got=%h exp=%h", obs, e); end
    cyc(1, 0, 1, 0, 1);
    e = q.pop_front();
    checks++;
    if (obs !== e || obs !== out_t'(0)) begin failures++; $display("FAIL reset_mid got=%h exp=%h", obs, e); end
  endtask
  task automatic test_saturate;
    select(2);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 0, 1);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL saturate s%0d got=%h exp=%h", i, obs, e); end
    end
    checks++;
    if (obs.ft !== 16'd15) begin failures++; $display("FAIL saturate_total got=%0d exp=15", obs.ft); end
  endtask
  task automatic test_random(input int s);
    select(s);
    cyc(1, 0, 0, 0, 0); void'(q.pop_front());
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(99) == 0, $urandom_range(79) == 0, $urandom_range(3) != 0,
          $urandom_range(5) != 0, $urandom_range(2) != 0);
      e = q.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL random%0d c%0d got=%h exp=%h", s, i, obs, e); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset;
    test_pass_fail;
    test_all_fail;
    test_overrun;
    test_gaps;
    test_halt;
    test_reset_mid;
    test_saturate;
    test_random(0);
    test_random(1);
    test_random(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
